adder_share_arb: RTL and testbench

Round-robin arbiter that shares one registered adder pipeline (two register stages, input and output) among NUM_REQ requesters. Each cycle it grants at most one valid request and presents the winner's operands to the adder. It carries the winner's index through a tag pipeline matched to the adder latency, so each result returns to the requester that issued it. It sits between the requester-side operand interfaces and the adder datapath.

---
 rtl/adder_arb_pkg.sv | 17 +
 rtl/adder_arb_rr_pick.sv | 30 +++
 rtl/adder_share_arb.sv | 110 +++++++++++
 tb/tb_adder_share_arb.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/adder_arb_pkg.sv
// Shared types and defaults for the adder-sharing arbiter.
package adder_arb_pkg;
  localparam int NUM_REQ_DEF = 4;
  localparam int WIDTH_DEF   = 4;
  localparam int LAT_DEF     = 2;
  localparam int IDX_MAX_W   = 3;  // wide enough for up to 8 requesters
  localparam int IDX_W       = $clog2(NUM_REQ_DEF);

  typedef struct packed {
    logic                 vld;
    logic [IDX_MAX_W-1:0] idx;
  } tag_t;

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/adder_arb_rr_pick.sv
// Combinational round-robin picker: first set request strictly after ptr, with wrap.
module adder_arb_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IW      = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IW-1:0]      idx_o,
  output logic               any_o
);
  int c;

  // Walk offsets from farthest to nearest so the nearest requester overwrites.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    c     = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      c = (int'(ptr_i) + k) % NUM_REQ;
      if (req_i[IW'(c)]) begin
        gnt_o        = '0;
        gnt_o[IW'(c)] = 1'b1;
        idx_o        = IW'(c);
        any_o        = 1'b1;
      end
    end
  end
endmodule

// File: rtl/adder_share_arb.sv
// Shares one external registered adder among NUM_REQ requesters, routing results back by tag.
// ADDER_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module adder_share_arb
  import adder_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int WIDTH   = WIDTH_DEF,
  parameter int LAT     = LAT_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     arb_en,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]         add_a,
  output logic [WIDTH-1:0]         add_b,
  input  logic [WIDTH-1:0]         add_sum,
  input  logic                     add_carry,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_carry,
  output logic                     busy
);
  localparam int IW = idx_w(NUM_REQ);

  logic [NUM_REQ-1:0] req_m, gnt;
  logic [IW-1:0]      win;
  logic               any;

  assign req_m = req_valid & {NUM_REQ{arb_en}};

`ifdef ADDER_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt = '0;
    win = '0;
    any = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_m[i]) begin
        gnt    = '0;
        gnt[i] = 1'b1;
        win    = IW'(i);
        any    = 1'b1;
      end
    end
  end
`else
  logic [IW-1:0] ptr_q, ptr_d;

  adder_arb_rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
    .req_i (req_m),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (win),
    .any_o (any)
  );

  assign ptr_d = any ? win : ptr_q;

  // Reset to the last index so requester 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= IW'(NUM_REQ - 1);
    else     ptr_q <= ptr_d;
  end
`endif

  assign req_ready = gnt;

  logic [NUM_REQ-1:0][WIDTH-1:0] a_m, b_m;
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_mux
    assign a_m[i] = gnt[i] ? req_a[i*WIDTH +: WIDTH] : '0;
    assign b_m[i] = gnt[i] ? req_b[i*WIDTH +: WIDTH] : '0;
  end

  always_comb begin
    add_a = '0;
    add_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      add_a = add_a | a_m[i];
      add_b = add_b | b_m[i];
    end
  end

  tag_t tag_q [LAT];
  tag_t tag_d;

  assign tag_d = '{vld: any, idx: IDX_MAX_W'(win)};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < LAT; s++) tag_q[s] <= '0;
    end else begin
      tag_q[0] <= tag_d;
      for (int s = 1; s < LAT; s++) tag_q[s] <= tag_q[s-1];
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_rsp
    assign rsp_valid[i] = tag_q[LAT-1].vld && (tag_q[LAT-1].idx == IDX_MAX_W'(i));
  end

  assign rsp_sum   = (|rsp_valid) ? add_sum   : '0;
  assign rsp_carry = (|rsp_valid) ? add_carry : 1'b0;

  always_comb begin
    busy = 1'b0;
    for (int s = 0; s < LAT; s++) busy = busy | tag_q[s].vld;
  end
endmodule

// File: tb/tb_adder_share_arb.sv
// Randomized bench for adder_share_arb against a queue-based reference model, with a registered LAT=2 adder.
module tb_adder_share_arb;
  localparam int N = 4;
  localparam int W = 4;
  localparam int L = 2;

  logic             clk, rst, arb_en;
  logic [N-1:0]     req_valid, req_ready, rsp_valid;
  logic [N*W-1:0]   req_a, req_b;
  logic [W-1:0]     add_a, add_b, add_sum, rsp_sum;
  logic             add_carry, rsp_carry, busy;

  adder_share_arb #(.NUM_REQ(N), .WIDTH(W), .LAT(L)) dut (
    .clk(clk), .rst(rst), .arb_en(arb_en),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum), .add_carry(add_carry),
    .rsp_valid(rsp_valid), .rsp_sum(rsp_sum), .rsp_carry(rsp_carry), .busy(busy)
  );

  // External registered adder: operand stage then result stage.
  logic [W-1:0] ad_a_q, ad_b_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ad_a_q <= '0; ad_b_q <= '0; add_sum <= '0; add_carry <= 1'b0;
    end else begin
      ad_a_q <= add_a; ad_b_q <= add_b;
      {add_carry, add_sum} <= {1'b0, ad_a_q} + {1'b0, ad_b_q};
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int due; int idx; int total; } pend_t;
  pend_t        m_q[$];
  int           m_ptr, cyc, n_chk, n_err;
  logic [N-1:0] last_gnt;
  logic [31:0]  obs_ready, obs_rsp, obs_sum, obs_carry, obs_busy;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Compare all outputs of the current cycle with the model, then advance the model.
  task automatic model_check();
    int w, ai, bi, e_idx, e_tot;
    bit hit, e_busy;
    w = -1;
    if (arb_en) begin
`ifdef ADDER_ARB_FIXED_PRIO_EN
      for (int c = N - 1; c >= 0; c--) if (req_valid[c]) w = c;
`else
      for (int k = N; k >= 1; k--) if (req_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
`endif
    end
    ai = (w >= 0) ? int'(req_a[w*W +: W]) : 0;
    bi = (w >= 0) ? int'(req_b[w*W +: W]) : 0;
    chk("ready", 32'(req_ready), (w >= 0) ? (32'd1 << w) : 32'd0);
    chk("add_a", 32'(add_a), 32'(ai));
    chk("add_b", 32'(add_b), 32'(bi));
    hit = 0; e_idx = 0; e_tot = 0; e_busy = 0;
    foreach (m_q[j]) begin
      if (m_q[j].due == cyc) begin hit = 1; e_idx = m_q[j].idx; e_tot = m_q[j].total; end
      if (m_q[j].due >= cyc) e_busy = 1;
    end
    chk("rsp_valid", 32'(rsp_valid), hit ? (32'd1 << e_idx) : 32'd0);
    chk("rsp_sum",   32'(rsp_sum),   hit ? 32'(e_tot % (1 << W)) : 32'd0);
    chk("rsp_carry", 32'(rsp_carry), hit ? 32'(e_tot >> W) : 32'd0);
    chk("busy",      32'(busy),      32'(e_busy));
    obs_ready = 32'(req_ready); obs_rsp = 32'(rsp_valid); obs_sum = 32'(rsp_sum);
    obs_carry = 32'(rsp_carry); obs_busy = 32'(busy);
    for (int j = m_q.size() - 1; j >= 0; j--) if (m_q[j].due <= cyc) m_q.delete(j);
    last_gnt = '0;
    if (w >= 0) begin
      m_q.push_back('{due: cyc + L, idx: w, total: ai + bi});
      m_ptr = w;
      last_gnt[w] = 1'b1;
    end
  endtask

  task automatic cyc_run(input logic [N-1:0] v, input logic [N*W-1:0] a, input logic [N*W-1:0] b,
                         input logic en);
    req_valid = v; req_a = a; req_b = b; arb_en = en;
    @(negedge clk);
    model_check();
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; arb_en = 1'b1;
    m_q.delete(); m_ptr = N - 1; last_gnt = '0;
    @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_sum",   32'(rsp_sum),   32'd0);
    chk("rst_rsp_carry", 32'(rsp_carry), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    cyc++;
  endtask

  initial begin
    logic [N-1:0]   v;
    logic [N*W-1:0] a, b;
    n_chk = 0; n_err = 0; cyc = 0;
    rst = 1'b1; arb_en = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
    @(posedge clk); #1;
    do_reset();

    // First transaction: 3 + 4 from requester 0, result two cycles later.
    cyc_run(4'b0001, 16'h0003, 16'h0004, 1'b1);
    chk("t1_ready", obs_ready, 32'h1);
    cyc_run('0, '0, '0, 1'b1);
    cyc_run('0, '0, '0, 1'b1);
    chk("t1_rsp", obs_rsp, 32'h1);
    chk("t1_sum", obs_sum, 32'd7);
    chk("t1_carry", obs_carry, 32'd0);

    // All requesters continuously valid.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      cyc_run(4'b1111, 16'h4321, 16'h1111, 1'b1);
`ifdef ADDER_ARB_FIXED_PRIO_EN
      chk("fp_order", obs_ready, 32'h1);
`else
      chk("rr_order", obs_ready, 32'd1 << (k % 4));
`endif
    end
    cyc_run('0, '0, '0, 1'b1);
    cyc_run('0, '0, '0, 1'b1);

    // Overflow wrap with carry from requester 2.
    cyc_run(4'b0100, 16'h0F00, 16'h0100, 1'b1);
    cyc_run(4'b0100, 16'h0900, 16'h0900, 1'b1);
    cyc_run('0, '0, '0, 1'b1);
    chk("ovf1_rsp", obs_rsp, 32'h4);
    chk("ovf1_sum", obs_sum, 32'd0);
    chk("ovf1_carry", obs_carry, 32'd1);
    cyc_run('0, '0, '0, 1'b1);
    chk("ovf2_sum", obs_sum, 32'd2);
    chk("ovf2_carry", obs_carry, 32'd1);

    // Grant enable dropped with two results in flight.
    do_reset();
    cyc_run(4'b1111, 16'h4321, 16'h2222, 1'b1);
    cyc_run(4'b1111, 16'h4321, 16'h2222, 1'b1);
    cyc_run(4'b1111, 16'h4321, 16'h2222, 1'b0);
    chk("en0_ready", obs_ready, 32'd0);
    chk("en0_rsp0", obs_rsp, 32'h1);
    chk("en0_busy", obs_busy, 32'd1);
    cyc_run(4'b1111, 16'h4321, 16'h2222, 1'b0);
    chk("en0_rsp1", obs_rsp, 32'h2);
    cyc_run(4'b1111, 16'h4321, 16'h2222, 1'b0);
    chk("en0_drained", obs_busy, 32'd0);
    cyc_run(4'b1111, 16'h4321, 16'h2222, 1'b1);
`ifdef ADDER_ARB_FIXED_PRIO_EN
    chk("en1_ready", obs_ready, 32'h1);
`else
    chk("en1_ready", obs_ready, 32'h4);
`endif
    cyc_run('0, '0, '0, 1'b1);
    cyc_run('0, '0, '0, 1'b1);

    // Reset one cycle after a grant discards the in-flight result.
    do_reset();
    cyc_run(4'b0010, 16'h0050, 16'h0060, 1'b1);
    do_reset();
    cyc_run('0, '0, '0, 1'b1);
    chk("rst_no_rsp", obs_rsp, 32'd0);
    cyc_run(4'b1111, 16'h1111, 16'h1111, 1'b1);
    chk("rst_first_win", obs_ready, 32'h1);
    cyc_run('0, '0, '0, 1'b1);
    cyc_run('0, '0, '0, 1'b1);

`ifdef ADDER_ARB_FIXED_PRIO_EN
    do_reset();
    for (int k = 0; k < 6; k++) begin
      cyc_run(4'b0110, 16'h0330, 16'h0110, 1'b1);
      chk("fp_low_wins", obs_ready, 32'h2);
    end
`endif

    // Random traffic; requesters hold operands until granted.
    v = '0; a = '0; b = '0;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < N; i++) begin
        if (!(v[i] && !last_gnt[i])) begin
          v[i] = 1'($urandom_range(0, 1));
          a[i*W +: W] = W'($urandom);
          b[i*W +: W] = W'($urandom);
        end
      end
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
        v = '0;
      end else begin
        cyc_run(v, a, b, $urandom_range(0, 9) != 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
